// File: rtl/module_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// module_spi_master_ctrl
//
// Purpose:
//   SPI master (mode 0, MSB first) that streams bytes out of a TX buffer and
//   writes the bytes received on miso_i into an RX buffer. A transaction is
//   started by the send bit of the control word. It moves bytes 0..n_tx_end
//   and ends with a one-cycle proccess_o pulse. Every byte takes exactly
//   2 + 16*CLK_DIV clock cycles.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   cntr_str_i   control word: [0] send, [1] cs_ctrl, [2] all_1s, [3] all_0s,
//                [13:4] n_tx_end (index of the last byte); other bits unused
//   tx_data_i    TX buffer read data (synchronous read, 1-cycle latency)
//   tx_addr_o    TX buffer read address
//   rx_data_o    byte written to the RX buffer
//   rx_addr_o    RX buffer write address
//   rx_we_o      RX buffer write strobe
//   we_rx_o      update strobe for the received-count register field
//   in_rx_o      number of bytes received so far
//   proccess_o   one-cycle transaction-complete pulse
//   busy_o       high while a transaction is in progress
//   sclk_o, mosi_o, cs_n_o, miso_i   SPI pins
//
// Configuration:
//   SPI_LOOPBACK_EN  when defined, the receive shift register takes its input
//                    from mosi_o and miso_i is ignored.
// ---------------------------------------------------------------------------
module module_spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] cntr_str_i,
  input  logic [7:0]  tx_data_i,
  output logic [9:0]  tx_addr_o,
  output logic [7:0]  rx_data_o,
  output logic [9:0]  rx_addr_o,
  output logic        rx_we_o,
  output logic        we_rx_o,
  output logic [9:0]  in_rx_o,
  output logic        proccess_o,
  output logic        busy_o,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        cs_n_o,
  input  logic        miso_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Control fields captured when a transaction starts
  logic        r_all1;
  logic        r_all0;
  logic [9:0]  r_n_tx_end;

  logic [9:0]  r_idx;
  logic [7:0]  r_div;
  logic [3:0]  r_half;
  logic [7:0]  r_tx_sh;
  logic [7:0]  r_rx_sh;

  logic        r_sclk;
  logic        r_mosi;
  logic        r_cs_n;
  logic        r_busy;
  logic        r_rx_we;
  logic        r_we_rx;
  logic        r_proc;
  logic [9:0]  r_tx_addr;
  logic [9:0]  r_rx_addr;
  logic [7:0]  r_rx_data;
  logic [9:0]  r_in_rx;

  logic        w_div_end;
  logic        w_last_half;
  logic        w_more;
  logic [7:0]  w_tx_byte;
  logic        w_din;
  logic        w_unused_cntr;

  assign w_unused_cntr = ^cntr_str_i[31:14];

  assign w_div_end   = (r_div == 8'(CLK_DIV - 1));
  assign w_last_half = (r_half == 4'd15);
  assign w_more      = (r_idx < r_n_tx_end);

`ifdef SPI_LOOPBACK_EN
  logic w_unused_miso;
  assign w_unused_miso = miso_i;
  assign w_din         = r_mosi;
`else
  assign w_din         = miso_i;
`endif

  // TX byte source selection; all_1s wins over all_0s
  always_comb begin
    w_tx_byte = tx_data_i;
    if (r_all1) begin
      w_tx_byte = 8'hFF;
    end else if (r_all0) begin
      w_tx_byte = 8'h00;
    end else begin
      w_tx_byte = tx_data_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cntr_str_i[0]) begin
          w_next = ST_LOAD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOAD:  w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_div_end && w_last_half) begin
          w_next = ST_STORE;
        end else begin
          w_next = ST_SHIFT;
        end
      end
      ST_STORE: begin
        if (w_more) begin
          w_next = ST_LOAD;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath, SPI pins and strobes, all registered
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_all1     <= 1'b0;
      r_all0     <= 1'b0;
      r_n_tx_end <= 10'd0;
      r_idx      <= 10'd0;
      r_div      <= 8'd0;
      r_half     <= 4'd0;
      r_tx_sh    <= 8'd0;
      r_rx_sh    <= 8'd0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_rx_we    <= 1'b0;
      r_we_rx    <= 1'b0;
      r_proc     <= 1'b0;
      r_tx_addr  <= 10'd0;
      r_rx_addr  <= 10'd0;
      r_rx_data  <= 8'd0;
      r_in_rx    <= 10'd0;
    end else begin
      r_rx_we <= 1'b0;
      r_we_rx <= 1'b0;
      r_proc  <= 1'b0;
      r_busy  <= (w_next != ST_IDLE);
      // Outside a transaction chip select follows cs_ctrl directly
      r_cs_n  <= (w_next == ST_IDLE) ? ~cntr_str_i[1] : 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sclk <= 1'b0;
          r_mosi <= 1'b0;
          if (w_next == ST_LOAD) begin
            r_all1     <= cntr_str_i[2];
            r_all0     <= cntr_str_i[3];
            r_n_tx_end <= cntr_str_i[13:4];
            r_idx      <= 10'd0;
            r_tx_addr  <= 10'd0;
            r_in_rx    <= 10'd0;
          end
        end
        ST_LOAD: begin
          // tx_addr_o has been stable since the previous cycle, so the
          // buffer output already belongs to this byte
          r_tx_sh <= w_tx_byte;
          r_mosi  <= w_tx_byte[7];
          r_div   <= 8'd0;
          r_half  <= 4'd0;
          r_sclk  <= 1'b0;
        end
        ST_SHIFT: begin
          if (w_div_end) begin
            r_div  <= 8'd0;
            r_sclk <= ~r_sclk;
            r_half <= r_half + 4'd1;
            if (!r_sclk) begin
              r_rx_sh <= {r_rx_sh[6:0], w_din};
            end else begin
              r_tx_sh <= {r_tx_sh[6:0], 1'b0};
              r_mosi  <= r_tx_sh[6];
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
          if (w_next == ST_STORE) begin
            r_rx_we   <= 1'b1;
            r_we_rx   <= 1'b1;
            r_rx_addr <= r_idx;
            r_rx_data <= r_rx_sh;
            r_in_rx   <= r_idx + 10'd1;
            // Pre-address the next byte so its data is ready during LOAD
            r_tx_addr <= w_more ? (r_idx + 10'd1) : 10'd0;
          end
        end
        ST_STORE: begin
          if (w_more) begin
            r_idx <= r_idx + 10'd1;
          end
          if (w_next == ST_DONE) begin
            r_proc <= 1'b1;
          end
        end
        ST_DONE: begin
          r_mosi <= 1'b0;
        end
        default: begin
          r_sclk <= 1'b0;
        end
      endcase
    end
  end

  assign tx_addr_o  = r_tx_addr;
  assign rx_data_o  = r_rx_data;
  assign rx_addr_o  = r_rx_addr;
  assign rx_we_o    = r_rx_we;
  assign we_rx_o    = r_we_rx;
  assign in_rx_o    = r_in_rx;
  assign proccess_o = r_proc;
  assign busy_o     = r_busy;
  assign sclk_o     = r_sclk;
  assign mosi_o     = r_mosi;
  assign cs_n_o     = r_cs_n;

endmodule

// File: tb/tb_module_spi_master_ctrl.sv
module tb_module_spi_master_ctrl;

  localparam int CLK_DIV  = 2;
  localparam int BYTE_CYC = 2 + 16 * CLK_DIV;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] cntr_str_i = 32'd0;
  logic [7:0]  tx_data_i = 8'd0;
  logic [9:0]  tx_addr_o;
  logic [7:0]  rx_data_o;
  logic [9:0]  rx_addr_o;
  logic        rx_we_o;
  logic        we_rx_o;
  logic [9:0]  in_rx_o;
  logic        proccess_o;
  logic        busy_o;
  logic        sclk_o;
  logic        mosi_o;
  logic        cs_n_o;
  logic        miso_i;

  module_spi_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .cntr_str_i (cntr_str_i),
    .tx_data_i  (tx_data_i),
    .tx_addr_o  (tx_addr_o),
    .rx_data_o  (rx_data_o),
    .rx_addr_o  (rx_addr_o),
    .rx_we_o    (rx_we_o),
    .we_rx_o    (we_rx_o),
    .in_rx_o    (in_rx_o),
    .proccess_o (proccess_o),
    .busy_o     (busy_o),
    .sclk_o     (sclk_o),
    .mosi_o     (mosi_o),
    .cs_n_o     (cs_n_o),
    .miso_i     (miso_i)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] tx_mem   [0:1023];
  logic [7:0] miso_mem [0:1023];
  logic [7:0] rx_mem   [0:1023];

  int err_cnt = 0;
  int chk_cnt = 0;
  int proc_cnt = 0;

  logic [17:0] exp_rx_q [$];
  logic [7:0]  exp_mosi_q [$];
  logic [17:0] mon_e;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // synchronous-read TX buffer
  always @(posedge clk_i) tx_data_i <= tx_mem[tx_addr_o];

  // mode-0 SPI slave: presents miso before the rising edge, advances on falling
  logic [9:0] s_byte = 10'd0;
  logic [2:0] s_bit  = 3'd0;
  always @(negedge sclk_o or posedge cs_n_o) begin
    if (cs_n_o) begin
      s_byte = 10'd0;
      s_bit  = 3'd0;
    end else begin
      if (s_bit == 3'd7) s_byte = s_byte + 10'd1;
      s_bit = s_bit + 3'd1;
    end
  end
  assign miso_i = miso_mem[s_byte][3'd7 - s_bit];

  // capture mosi on sclk rising edges and score whole bytes
  logic [7:0] m_sh  = 8'd0;
  logic [3:0] m_cnt = 4'd0;
  always @(posedge sclk_o or posedge cs_n_o) begin
    if (cs_n_o) begin
      m_cnt = 4'd0;
    end else begin
      m_sh  = {m_sh[6:0], mosi_o};
      m_cnt = m_cnt + 4'd1;
      if (m_cnt == 4'd8) begin
        m_cnt = 4'd0;
        check_val("mosi_byte", {24'd0, m_sh},
                  (exp_mosi_q.size() != 0) ? {24'd0, exp_mosi_q.pop_front()} : 32'hDEAD_BEEF);
      end
    end
  end

  // output monitor: RX writes, count updates, strobe exclusivity
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (rx_we_o) begin
        mon_e = (exp_rx_q.size() != 0) ? exp_rx_q.pop_front() : 18'h3FFFF;
        check_val("rx_addr", {22'd0, rx_addr_o}, {22'd0, mon_e[17:8]});
        check_val("rx_data", {24'd0, rx_data_o}, {24'd0, mon_e[7:0]});
        check_val("we_rx_with_rx_we", {31'd0, we_rx_o}, 32'd1);
        check_val("in_rx", {22'd0, in_rx_o}, {22'd0, 10'(mon_e[17:8] + 10'd1)});
        rx_mem[rx_addr_o] = rx_data_o;
      end else if (we_rx_o) begin
        check_val("we_rx_alone", {31'd0, rx_we_o}, 32'd1);
      end
      if (proccess_o) begin
        proc_cnt++;
        check_val("proc_excl", {30'd0, rx_we_o, we_rx_o}, 32'd0);
      end
    end
  end

  function automatic logic [7:0] exp_rx(input int idx, input logic [7:0] txb);
`ifdef SPI_LOOPBACK_EN
    return txb;
`else
    return miso_mem[idx];
`endif
  endfunction

  task automatic push_exp(input logic [31:0] cw);
    logic [7:0] txb;
    for (int i = 0; i <= int'(cw[13:4]); i++) begin
      txb = cw[2] ? 8'hFF : (cw[3] ? 8'h00 : tx_mem[i]);
      exp_mosi_q.push_back(txb);
      exp_rx_q.push_back({10'(i), exp_rx(i, txb)});
    end
  endtask

  // Runs one transaction from a negedge; cyc=1 is the LOAD cycle
  task automatic do_txn(input string tag, input logic [31:0] cw, input bit hold_send,
                        input int mid_at, input logic [31:0] mid_cw, input int exp_cyc);
    int cyc;
    int p0;
    push_exp(cw);
    p0 = proc_cnt;
    cntr_str_i = cw;
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) begin
        check_val({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        check_val({tag, "_cs"}, {31'd0, cs_n_o}, 32'd0);
        if (!hold_send) cntr_str_i[0] = 1'b0;
      end
      if (cyc == mid_at) cntr_str_i = mid_cw;
    end while (!proccess_o && cyc < exp_cyc + 10);
    check_val({tag, "_proc_seen"}, {31'd0, proccess_o}, 32'd1);
    check_val({tag, "_cycles"}, cyc, exp_cyc);
    cntr_str_i = 32'd0;
    repeat (4) @(negedge clk_i);
    check_val({tag, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
    check_val({tag, "_idle_cs"}, {31'd0, cs_n_o}, 32'd1);
    check_val({tag, "_proc_cnt"}, proc_cnt - p0, 32'd1);
    check_val({tag, "_rx_left"}, exp_rx_q.size(), 32'd0);
    check_val({tag, "_mosi_left"}, exp_mosi_q.size(), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_cs"}, {31'd0, cs_n_o}, 32'd1);
    check_val({tag, "_sclk_mosi"}, {30'd0, sclk_o, mosi_o}, 32'd0);
    check_val({tag, "_strobes"}, {28'd0, rx_we_o, we_rx_o, proccess_o, busy_o}, 32'd0);
    check_val({tag, "_addrs"}, {12'd0, tx_addr_o, rx_addr_o}, 32'd0);
    check_val({tag, "_data"}, {14'd0, rx_data_o, in_rx_o}, 32'd0);
  endtask

  initial begin
    int n;
    int p0;
    for (int i = 0; i < 1024; i++) begin
      tx_mem[i]   = 8'(i * 7 + 3);
      miso_mem[i] = 8'(i * 13 + 8'h3C);
      rx_mem[i]   = 8'hEE;
    end
    tx_mem[0] = 8'hA5;

    repeat (3) @(negedge clk_i);
    check_reset_outs("reset");
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // single byte, A5 out, 3C in
    do_txn("one_byte", 32'h0000_0001, 1'b0, 0, 32'd0, BYTE_CYC + 1);
    check_val("one_byte_rx0", {24'd0, rx_mem[0]}, {24'd0, exp_rx(0, 8'hA5)});
    check_val("one_byte_in_rx", {22'd0, in_rx_o}, 32'd1);

    // all_1s and all_0s both set: four FF bytes
    do_txn("all1s", 32'h0000_003D, 1'b0, 0, 32'd0, 4 * BYTE_CYC + 1);

    // send held high, control word altered mid-transfer
    tx_mem[0] = 8'h12;
    tx_mem[1] = 8'h34;
    do_txn("held_send", 32'h0000_0011, 1'b1, 20, 32'h0000_0055, 2 * BYTE_CYC + 1);

    // two data bytes 5A, C3
    tx_mem[0] = 8'h5A;
    tx_mem[1] = 8'hC3;
    do_txn("two_bytes", 32'h0000_0011, 1'b0, 0, 32'd0, 2 * BYTE_CYC + 1);
    check_val("two_bytes_rx0", {24'd0, rx_mem[0]}, {24'd0, exp_rx(0, 8'h5A)});
    check_val("two_bytes_rx1", {24'd0, rx_mem[1]}, {24'd0, exp_rx(1, 8'hC3)});

    // manual chip select while idle
    cntr_str_i = 32'h0000_0002;
    @(negedge clk_i);
    check_val("csctrl_on", {29'd0, cs_n_o, sclk_o, busy_o}, 32'd0);
    cntr_str_i = 32'h0000_0000;
    @(negedge clk_i);
    check_val("csctrl_off", {31'd0, cs_n_o}, 32'd1);

    // reset during bit 5 of byte 1
    rx_mem[1] = 8'hEE;
    push_exp(32'h0000_0021);
    p0 = proc_cnt;
    cntr_str_i = 32'h0000_0021;
    @(negedge clk_i);
    cntr_str_i = 32'h0000_0000;
    n = 0;
    while (!(s_byte == 10'd1 && s_bit == 3'd2) && n < 4 * BYTE_CYC) begin
      @(negedge clk_i);
      n++;
    end
    check_val("rst_mid_reached", {31'd0, busy_o}, 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_val("rst_mid_cs", {31'd0, cs_n_o}, 32'd1);
    check_val("rst_mid_sclk", {31'd0, sclk_o}, 32'd0);
    check_val("rst_mid_pending", exp_rx_q.size(), 32'd2);
    exp_rx_q.delete();
    exp_mosi_q.delete();
    repeat (3) @(negedge clk_i);
    check_reset_outs("rst_mid_hold");
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check_val("rst_mid_no_proc", proc_cnt - p0, 32'd0);
    check_val("rst_mid_rx1", {24'd0, rx_mem[1]}, 32'h0000_00EE);

    // full 1024-byte transfer, addresses 0..1023
    do_txn("max_len", 32'h0000_3FF1, 1'b0, 0, 32'd0, 1024 * BYTE_CYC + 1);
    check_val("max_len_last", {24'd0, rx_mem[1023]}, {24'd0, exp_rx(1023, tx_mem[1023])});

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
